prog_delay: RTL and testbench
=============================

PROG_DELAY -- requirements
Module: prog_delay

Interface
REQ-001 Parameter CH, default 4: number of independent delay channels, range 1..32.
REQ-002 Parameter CW, default 8: per-channel delay count width, range 1..16.
REQ-003 Parameter HOLD, default 0: 0 = fin is a one-cycle pulse; 1 = fin is held high until req falls (4-phase).
REQ-004 Parameter RETRIG, default 0: 1 = a req rising edge during counting reloads the count; 0 = the edge is ignored.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-007 req  input  CH  per-channel request; a rising edge starts a delay.
REQ-008 dly  input  CH*CW  per-channel delay count; channel i uses bits [i*CW +: CW].
REQ-009 abort  input  CH  per-channel cancel, level-sampled.
REQ-010 fin  output  CH  per-channel completion, registered.
REQ-011 busy  output  CH  per-channel: high in COUNT or DONE, registered.

Function
REQ-012 Channels SHALL be fully independent; no shared state between channels.
REQ-013 Each channel SHALL register req as req_q; rise = req & ~req_q.
REQ-014 Each channel SHALL run an FSM with states IDLE, COUNT and DONE, plus a CW-bit counter cnt.
REQ-015 IDLE, rise on edge k -> COUNT, cnt <= dly slice; dly is sampled only at load, and later changes are ignored.
REQ-016 COUNT: if cnt==0 -> DONE, else cnt <= cnt-1.
REQ-017 Latency: with rise on edge k and dly=D, fin SHALL be high after edge k+D+1; D=0 gives 1 cycle, D=2^CW-1 gives 2^CW cycles.
REQ-018 DONE, HOLD=0: fin high for exactly one cycle, then IDLE unconditionally.
REQ-019 DONE, HOLD=1: fin stays high while req=1; when req=0 -> IDLE, and fin is low from the next cycle.
REQ-020 COUNT, rise, RETRIG=1: cnt <= dly slice (restart), state stays COUNT; this takes priority over the cnt==0 exit.
REQ-021 COUNT, rise, RETRIG=0: no effect.
REQ-022 abort=1 in COUNT or DONE -> IDLE next edge with fin=0; abort has priority over rise, retrigger and terminal count; abort in IDLE has no effect, and a coincident rise in IDLE is discarded.
REQ-023 A rise while in DONE SHALL be ignored; no queuing of requests.
REQ-024 busy SHALL be 1 exactly when the state is COUNT or DONE.
REQ-025 fin SHALL be 1 exactly when the state is DONE; it is never combinational from inputs.
REQ-026 Counter arithmetic SHALL be unsigned CW-bit; cnt never decrements below 0 and never wraps.

Reset
REQ-027 With rst=1 at a clock edge, every channel SHALL go to: state IDLE, cnt=0, fin=0, busy=0.
REQ-028 req_q SHALL reset to 1, so a req held high through reset release does not trigger; req must fall then rise.
REQ-029 Reset mid-COUNT or mid-DONE SHALL abandon the operation with no fin pulse.
REQ-030 rst SHALL override abort and req in the same cycle.

Structure
REQ-031 Shared package prog_delay_pkg SHALL hold the state typedef (IDLE=2'b00, COUNT=2'b01, DONE=2'b10) and default CW/CH constants.
REQ-032 One sub-module, prog_delay_chan (params CW, HOLD, RETRIG), SHALL implement a single channel; prog_delay instantiates CH copies in a generate loop.
REQ-033 The FSM SHALL treat the unused state encoding 2'b11 as IDLE.

Verification
REQ-034 CH=4, CW=8, HOLD=0: ch0 dly=5, req rise at edge 10 -> fin[0] high only after edge 16, for one cycle; busy[0] high after edges 10..16; other channels idle.
REQ-035 dly=0 and dly=255 on ch1 -> fin after 1 and 256 cycles respectively; no counter wrap.
REQ-036 HOLD=1, ch2 dly=3, rise at edge 0, req held high until edge 20 -> fin[2] high after edges 4..20, low after edge 21.
REQ-037 RETRIG=1, dly=10, rise at edge 0, second rise at edge 6 -> fin after edge 17 only; with RETRIG=0 -> fin after edge 11 only.
REQ-038 dly=8, abort pulse at edge 4 -> busy low after edge 5, no fin; rst pulse at edge 4 of a new run -> same outcome; req high across reset release -> no start.
REQ-039 All four channels started with different dly values in the same cycle -> each fin matches its own dly+1; dly changed mid-count has no effect.

Source files
------------

// File: rtl/prog_delay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_delay_pkg
// Description : Shared types and default sizes for the programmable
//               per-channel delay block.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_delay_pkg;

    // Channel FSM encoding; 2'b11 is unused and decoded as idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int c_DEF_CW = 8;
    localparam int c_DEF_CH = 4;

endpackage : prog_delay_pkg
`default_nettype wire

// File: rtl/prog_delay_chan.sv
`default_nettype none
// ============================================================================
// Module      : prog_delay_chan
// Description : One delay channel. A rising edge on i_req loads the delay
//               count; when the count has run down to zero o_fin is raised
//               (one pulse, or held while i_req stays high when HOLD=1).
// Revision    : 1.0 - initial release
// ============================================================================
module prog_delay_chan
    import prog_delay_pkg::*;
#(
    parameter int CW     = c_DEF_CW,
    parameter int HOLD   = 0,
    parameter int RETRIG = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [CW-1:0] i_dly,
    input  logic          i_abort,
    output logic          o_fin,
    output logic          o_busy
);

    localparam logic [CW-1:0] c_ONE = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_req_q;
    logic          r_fin;
    logic          r_busy;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_rise;

    // Next-state and counter decode; abort outranks every other event.
    always_comb begin
        w_rise      = i_req & ~r_req_q;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_COUNT: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if ((RETRIG != 0) && w_rise) begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = i_dly;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = r_cnt - c_ONE;
                end
            end
            ST_DONE: begin
                // A new rise here is dropped: requests are never queued.
                if (!i_abort && (HOLD != 0) && i_req) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                // Idle (and the unused encoding): start on a clean rise only.
                if (w_rise && !i_abort) begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = i_dly;
                end
            end
        endcase
    end

    // State, counter, request history and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req_q <= 1'b1;
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req_q <= i_req;
            r_fin   <= (w_state_nxt == ST_DONE);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_fin  = r_fin;
    assign o_busy = r_busy;

endmodule : prog_delay_chan
`default_nettype wire

// File: rtl/prog_delay.sv
`default_nettype none
// ============================================================================
// Module      : prog_delay
// Description : CH independent programmable delay channels sharing only the
//               clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_delay
    import prog_delay_pkg::*;
#(
    parameter int CH     = c_DEF_CH,
    parameter int CW     = c_DEF_CW,
    parameter int HOLD   = 0,
    parameter int RETRIG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    req,
    input  logic [CH*CW-1:0] dly,
    input  logic [CH-1:0]    abort,
    output logic [CH-1:0]    fin,
    output logic [CH-1:0]    busy
);

    for (genvar g = 0; g < CH; g++) begin : g_chan
        prog_delay_chan #(
            .CW     (CW),
            .HOLD   (HOLD),
            .RETRIG (RETRIG)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_req   (req[g]),
            .i_dly   (dly[g*CW +: CW]),
            .i_abort (abort[g]),
            .o_fin   (fin[g]),
            .o_busy  (busy[g])
        );
    end

endmodule : prog_delay
`default_nettype wire

// File: tb/tb_prog_delay.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_delay
// Description : Self-checking bench. Three instances: plain (HOLD=0,
//               RETRIG=0), held completion (HOLD=1) and retrigger (RETRIG=1).
//               Expected fin edges are queued when a request is driven and
//               matched when fin changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_delay;

    typedef struct {
        int d;
        int c;
        int kind;    // 1 = fin rises, 0 = fin falls
        int edge_n;  // clock edge after which the change is visible
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_a  [3];
    logic [31:0] dly_a  [3];
    logic [3:0]  abt_a  [3];
    logic [3:0]  fin_w  [3];
    logic [3:0]  busy_w [3];
    logic [3:0]  fin_prev [3];

    exp_t sb[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    // Edge counter: just after edge n it reads n.
    always @(posedge clk) cyc <= cyc + 1;

    prog_delay #(.CH(4), .CW(8), .HOLD(0), .RETRIG(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_a[0]), .dly(dly_a[0]),
        .abort(abt_a[0]), .fin(fin_w[0]), .busy(busy_w[0]));

    prog_delay #(.CH(4), .CW(8), .HOLD(1), .RETRIG(0)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_a[1]), .dly(dly_a[1]),
        .abort(abt_a[1]), .fin(fin_w[1]), .busy(busy_w[1]));

    prog_delay #(.CH(4), .CW(8), .HOLD(0), .RETRIG(1)) u_dut2 (
        .clk(clk), .rst(rst), .req(req_a[2]), .dly(dly_a[2]),
        .abort(abt_a[2]), .fin(fin_w[2]), .busy(busy_w[2]));

    task automatic check(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int c, input int kind, input int e);
        exp_t x;
        x.d = d; x.c = c; x.kind = kind; x.edge_n = e;
        sb.push_back(x);
    endtask

    task automatic set_dly(input int d, input int c, input int v);
        dly_a[d][c*8 +: 8] = 8'(v);
    endtask

    // Fin monitor: every transition must match a queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (fin_w[d][c] !== fin_prev[d][c]) begin
                    int idx;
                    int found;
                    idx   = 0;
                    found = 0;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (found == 0 && sb[i].d == d && sb[i].c == c &&
                            sb[i].kind == int'(fin_w[d][c])) begin
                            idx   = i;
                            found = 1;
                        end
                    end
                    if (found != 0) begin
                        check($sformatf("fin%0d d%0d c%0d edge", fin_w[d][c], d, c),
                              cyc, sb[idx].edge_n);
                        sb.delete(idx);
                    end else begin
                        check($sformatf("fin%0d d%0d c%0d unexpected at edge %0d",
                              fin_w[d][c], d, c, cyc), found, 1);
                    end
                    fin_prev[d][c] = fin_w[d][c];
                end
            end
        end
    end

    initial begin
        int k;
        int dv[4];
        for (int d = 0; d < 3; d++) begin
            req_a[d]    = '0;
            dly_a[d]    = '0;
            abt_a[d]    = '0;
            fin_prev[d] = '0;
        end

        // Reset state
        tick(); tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset fin d%0d", d), fin_w[d], 0);
            check($sformatf("reset busy d%0d", d), busy_w[d], 0);
        end
        tick();

        // Basic delay 5 on channel 0; busy window and isolation
        set_dly(0, 0, 5);
        req_a[0][0] = 1'b1;
        k = cyc + 1;
        push(0, 0, 1, k + 6);
        push(0, 0, 0, k + 7);
        tick();
        req_a[0][0] = 1'b0;
        check("busy0 after start", busy_w[0][0], 1);
        check("others idle", busy_w[0][3:1], 0);
        repeat (6) tick();
        check("busy0 in done", busy_w[0][0], 1);
        tick();
        check("busy0 after done", busy_w[0][0], 0);
        repeat (2) tick();

        // Delay extremes on channel 1: 0 and 255
        set_dly(0, 1, 0);
        req_a[0][1] = 1'b1;
        k = cyc + 1;
        push(0, 1, 1, k + 1);
        push(0, 1, 0, k + 2);
        tick();
        req_a[0][1] = 1'b0;
        repeat (3) tick();
        set_dly(0, 1, 255);
        req_a[0][1] = 1'b1;
        k = cyc + 1;
        push(0, 1, 1, k + 256);
        push(0, 1, 0, k + 257);
        tick();
        req_a[0][1] = 1'b0;
        repeat (255) tick();
        check("busy1 at max count", busy_w[0][1], 1);
        repeat (7) tick();
        check("busy1 after max", busy_w[0][1], 0);

        // Held completion: delay 3, req held 20 edges
        set_dly(1, 2, 3);
        req_a[1][2] = 1'b1;
        k = cyc + 1;
        push(1, 2, 1, k + 4);
        push(1, 2, 0, k + 21);
        tick();
        repeat (20) tick();
        check("hold fin still high", fin_w[1][2], 1);
        req_a[1][2] = 1'b0;
        repeat (2) tick();
        check("hold busy cleared", busy_w[1][2], 0);

        // Retrigger vs ignore: delay 10, second rise at edge k+6
        set_dly(0, 3, 10);
        set_dly(2, 3, 10);
        req_a[0][3] = 1'b1;
        req_a[2][3] = 1'b1;
        k = cyc + 1;
        push(2, 3, 1, k + 17);
        push(2, 3, 0, k + 18);
        push(0, 3, 1, k + 11);
        push(0, 3, 0, k + 12);
        tick();
        req_a[0][3] = 1'b0;
        req_a[2][3] = 1'b0;
        repeat (5) tick();
        req_a[0][3] = 1'b1;
        req_a[2][3] = 1'b1;
        tick();
        req_a[0][3] = 1'b0;
        req_a[2][3] = 1'b0;
        repeat (14) tick();

        // Abort mid-count: no fin
        set_dly(0, 0, 8);
        req_a[0][0] = 1'b1;
        tick();
        req_a[0][0] = 1'b0;
        repeat (4) tick();
        check("busy before abort", busy_w[0][0], 1);
        abt_a[0][0] = 1'b1;
        tick();
        abt_a[0][0] = 1'b0;
        check("busy after abort", busy_w[0][0], 0);
        repeat (12) tick();

        // Reset mid-count: no fin
        req_a[0][0] = 1'b1;
        tick();
        req_a[0][0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("busy after mid reset", busy_w[0][0], 0);
        repeat (12) tick();

        // Request held high across reset release must not start
        req_a[0][0] = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (15) tick();
        check("no start through reset", busy_w[0][0], 0);
        req_a[0][0] = 1'b0;
        tick();

        // Abort in idle discards a coincident rise
        req_a[0][1] = 1'b1;
        abt_a[0][1] = 1'b1;
        tick();
        abt_a[0][1] = 1'b0;
        check("idle abort drops rise", busy_w[0][1], 0);
        repeat (3) tick();
        check("idle abort stays idle", busy_w[0][1], 0);
        req_a[0][1] = 1'b0;
        tick();

        // All four channels at once; dly changed mid-count
        dv[0] = 3; dv[1] = 7; dv[2] = 1; dv[3] = 12;
        for (int c = 0; c < 4; c++) set_dly(0, c, dv[c]);
        req_a[0] = 4'hF;
        k = cyc + 1;
        for (int c = 0; c < 4; c++) begin
            push(0, c, 1, k + dv[c] + 1);
            push(0, c, 0, k + dv[c] + 2);
        end
        tick();
        req_a[0] = 4'h0;
        for (int c = 0; c < 4; c++) set_dly(0, c, 200);
        check("all busy", busy_w[0], 15);
        repeat (16) tick();

        // Wrap-up
        repeat (3) tick();
        check("scoreboard drained", sb.size(), 0);
        for (int d = 0; d < 3; d++)
            check($sformatf("final busy d%0d", d), busy_w[d], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_prog_delay
`default_nettype wire
